// File: rtl/ib_stream_monitor.sv
// ib_stream_monitor
// Passive protocol monitor for a LocalLink-style framed stream.
// It counts correctly terminated frames and records the length of the
// last one. It also raises sticky error flags and a one-cycle ERR_PULSE
// whenever a new framing error is seen.
// Optional feature: define IB_MON_MAXLEN_EN to enable the frame-length
// limit check (ERR_LONG against MAX_LEN). Without it, ERR_LONG is tied to 0.
module ib_stream_monitor #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 32,
  parameter int MAX_LEN    = 1024
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] DATA,
  input  logic                  SOF_N,
  input  logic                  EOF_N,
  input  logic                  SRC_RDY_N,
  input  logic                  DST_RDY_N,
  input  logic                  ERR_CLR,
  output logic                  IN_FRAME,
  output logic [CNT_WIDTH-1:0]  FRAME_CNT,
  output logic [LEN_WIDTH-1:0]  LAST_LEN,
  output logic                  ERR_SOF_EOF,
  output logic                  ERR_NO_SOF,
  output logic                  ERR_SOF_IN_FRAME,
  output logic                  ERR_LONG,
  output logic                  ERR_PULSE
);

  typedef enum logic {IDLE, FRAME} stateT;

  stateT                state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] frameCnt_q, frameCnt_d;
  logic [LEN_WIDTH-1:0] lastLen_q, lastLen_d;
  logic                 errSofEof_q, errSofEof_d;
  logic                 errNoSof_q, errNoSof_d;
  logic                 errSofInFrame_q, errSofInFrame_d;
  logic                 errPulse_q, errPulse_d;

  logic                 xfer;
  logic                 sof;
  logic                 eof;
  logic [LEN_WIDTH-1:0] lenInc;
  logic                 setSofEof;
  logic                 setNoSof;
  logic                 setSofInFrame;
  logic                 setLong;

  // DATA is carried only so the monitor can sit on a full bus tap.
  logic unusedData;
  assign unusedData = ^DATA;

  assign xfer   = ~SRC_RDY_N & ~DST_RDY_N;
  assign sof    = ~SOF_N;
  assign eof    = ~EOF_N;
  assign lenInc = (len_q == '1) ? len_q : len_q + LEN_WIDTH'(1);

`ifdef IB_MON_MAXLEN_EN
  localparam logic [LEN_WIDTH:0] MAX_LEN_W = (LEN_WIDTH+1)'(MAX_LEN);

  logic errLong_q, errLong_d;
  logic longSeen_q, longSeen_d;

  // Flag the first in-frame word that pushes the length past MAX_LEN; a new
  // SOF rearms the check so it fires at most once per frame.
  always_comb begin
    setLong    = 1'b0;
    longSeen_d = longSeen_q;
    errLong_d  = errLong_q & ~ERR_CLR;
    if (xfer && state_q == FRAME) begin
      if (sof) begin
        longSeen_d = 1'b0;
      end else if (({1'b0, len_q} + (LEN_WIDTH+1)'(1)) > MAX_LEN_W && !longSeen_q) begin
        setLong    = 1'b1;
        longSeen_d = 1'b1;
      end
    end else if (xfer && sof) begin
      longSeen_d = 1'b0;
    end
    if (setLong) errLong_d = 1'b1;
  end

  // Length-limit state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      errLong_q  <= 1'b0;
      longSeen_q <= 1'b0;
    end else begin
      errLong_q  <= errLong_d;
      longSeen_q <= longSeen_d;
    end
  end

  assign ERR_LONG = errLong_q;
`else
  logic unusedMaxLen;
  assign unusedMaxLen = (MAX_LEN > 0);
  assign setLong      = 1'b0;
  assign ERR_LONG     = 1'b0;
`endif

  // Frame tracking FSM: next state, counters and error events per transfer.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    frameCnt_d    = frameCnt_q;
    lastLen_d     = lastLen_q;
    setSofEof     = 1'b0;
    setNoSof      = 1'b0;
    setSofInFrame = 1'b0;
    if (xfer) begin
      unique case (state_q)
        IDLE: begin
          if (sof && !eof) begin
            state_d = FRAME;
            len_d   = LEN_WIDTH'(1);
          end else if (sof && eof) begin
            setSofEof = 1'b1;
          end else begin
            setNoSof = 1'b1;
          end
        end
        FRAME: begin
          if (!sof && !eof) begin
            len_d = lenInc;
          end else if (!sof && eof) begin
            frameCnt_d = frameCnt_q + CNT_WIDTH'(1);
            lastLen_d  = lenInc;
            state_d    = IDLE;
          end else if (sof && !eof) begin
            setSofInFrame = 1'b1;
            len_d         = LEN_WIDTH'(1);
          end else begin
            setSofInFrame = 1'b1;
            setSofEof     = 1'b1;
            state_d       = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    errSofEof_d     = (errSofEof_q & ~ERR_CLR) | setSofEof;
    errNoSof_d      = (errNoSof_q & ~ERR_CLR) | setNoSof;
    errSofInFrame_d = (errSofInFrame_q & ~ERR_CLR) | setSofInFrame;
    errPulse_d      = setSofEof | setNoSof | setSofInFrame | setLong;
  end

  // Main state register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= IDLE;
      len_q           <= '0;
      frameCnt_q      <= '0;
      lastLen_q       <= '0;
      errSofEof_q     <= 1'b0;
      errNoSof_q      <= 1'b0;
      errSofInFrame_q <= 1'b0;
      errPulse_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      frameCnt_q      <= frameCnt_d;
      lastLen_q       <= lastLen_d;
      errSofEof_q     <= errSofEof_d;
      errNoSof_q      <= errNoSof_d;
      errSofInFrame_q <= errSofInFrame_d;
      errPulse_q      <= errPulse_d;
    end
  end

  assign IN_FRAME         = (state_q == FRAME);
  assign FRAME_CNT        = frameCnt_q;
  assign LAST_LEN         = lastLen_q;
  assign ERR_SOF_EOF      = errSofEof_q;
  assign ERR_NO_SOF       = errNoSof_q;
  assign ERR_SOF_IN_FRAME = errSofInFrame_q;
  assign ERR_PULSE        = errPulse_q;

endmodule

// File: tb/tb_ib_stream_monitor.sv
// tb_ib_stream_monitor
// Directed self-checking bench for ib_stream_monitor with MAX_LEN=4.
// Expected ERR_LONG behaviour follows whether IB_MON_MAXLEN_EN is defined.
module tb_ib_stream_monitor;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [63:0] DATA = '0;
  logic        SOF_N = 1'b1;
  logic        EOF_N = 1'b1;
  logic        SRC_RDY_N = 1'b1;
  logic        DST_RDY_N = 1'b1;
  logic        ERR_CLR = 1'b0;
  logic        IN_FRAME;
  logic [31:0] FRAME_CNT;
  logic [15:0] LAST_LEN;
  logic        ERR_SOF_EOF;
  logic        ERR_NO_SOF;
  logic        ERR_SOF_IN_FRAME;
  logic        ERR_LONG;
  logic        ERR_PULSE;

  int assertCount = 0;
  int failCount   = 0;

`ifdef IB_MON_MAXLEN_EN
  localparam logic LONG_EN = 1'b1;
`else
  localparam logic LONG_EN = 1'b0;
`endif

  ib_stream_monitor #(
    .DATA_WIDTH(64),
    .LEN_WIDTH(16),
    .CNT_WIDTH(32),
    .MAX_LEN(4)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .DATA(DATA),
    .SOF_N(SOF_N),
    .EOF_N(EOF_N),
    .SRC_RDY_N(SRC_RDY_N),
    .DST_RDY_N(DST_RDY_N),
    .ERR_CLR(ERR_CLR),
    .IN_FRAME(IN_FRAME),
    .FRAME_CNT(FRAME_CNT),
    .LAST_LEN(LAST_LEN),
    .ERR_SOF_EOF(ERR_SOF_EOF),
    .ERR_NO_SOF(ERR_NO_SOF),
    .ERR_SOF_IN_FRAME(ERR_SOF_IN_FRAME),
    .ERR_LONG(ERR_LONG),
    .ERR_PULSE(ERR_PULSE)
  );

  // Free-running 10 ns clock.
  always #5 CLK = ~CLK;

  // Drive one cycle of inputs and return 1 ns after the edge that samples them.
  task automatic applyStimulus(input logic sofN, input logic eofN,
                               input logic srcN, input logic dstN,
                               input logic clr);
    SOF_N     = sofN;
    EOF_N     = eofN;
    SRC_RDY_N = srcN;
    DST_RDY_N = dstN;
    ERR_CLR   = clr;
    DATA      = {$urandom, $urandom};
    @(posedge CLK);
    #1;
    SRC_RDY_N = 1'b1;
    DST_RDY_N = 1'b1;
    ERR_CLR   = 1'b0;
  endtask

  task automatic xfer(input logic sofN, input logic eofN);
    applyStimulus(sofN, eofN, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkFlags(input string tag, input logic sofEof, input logic noSof,
                            input logic sofInFrame, input logic isLong);
    checkOutput({tag, ".sofEof"}, 32'(ERR_SOF_EOF), 32'(sofEof));
    checkOutput({tag, ".noSof"}, 32'(ERR_NO_SOF), 32'(noSof));
    checkOutput({tag, ".sofInFrame"}, 32'(ERR_SOF_IN_FRAME), 32'(sofInFrame));
    checkOutput({tag, ".long"}, 32'(ERR_LONG), 32'(isLong));
  endtask

  task automatic doReset();
    RESET = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    RESET = 1'b0;
  endtask

  initial begin
    // Reset state.
    doReset();
    checkOutput("rst.inFrame", 32'(IN_FRAME), 32'd0);
    checkOutput("rst.frameCnt", FRAME_CNT, 32'd0);
    checkOutput("rst.lastLen", 32'(LAST_LEN), 32'd0);
    checkOutput("rst.pulse", 32'(ERR_PULSE), 32'd0);
    checkFlags("rst", 1'b0, 1'b0, 1'b0, 1'b0);

    // SOF, 3 data, EOF: a clean 5-word frame.
    xfer(1'b0, 1'b1);
    checkOutput("f5.inFrameSof", 32'(IN_FRAME), 32'd1);
    xfer(1'b1, 1'b1);
    xfer(1'b1, 1'b1);
    xfer(1'b1, 1'b1);
    checkOutput("f5.cntBeforeEof", FRAME_CNT, 32'd0);
    xfer(1'b1, 1'b0);
    checkOutput("f5.frameCnt", FRAME_CNT, 32'd1);
    checkOutput("f5.lastLen", 32'(LAST_LEN), 32'd5);
    checkOutput("f5.inFrameEof", 32'(IN_FRAME), 32'd0);
    checkOutput("f5.pulse", 32'(ERR_PULSE), 32'd0);
    checkFlags("f5", 1'b0, 1'b0, 1'b0, 1'b0);

    // Single SOF+EOF transfer from IDLE.
    doReset();
    xfer(1'b0, 1'b0);
    checkFlags("se", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("se.pulse", 32'(ERR_PULSE), 32'd1);
    checkOutput("se.frameCnt", FRAME_CNT, 32'd0);
    checkOutput("se.inFrame", 32'(IN_FRAME), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("se.pulseGone", 32'(ERR_PULSE), 32'd0);
    checkOutput("se.sticky", 32'(ERR_SOF_EOF), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkFlags("se.clr", 1'b0, 1'b0, 1'b0, 1'b0);

    // SOF, data, SOF, data, EOF: first frame discarded, second counted as 3.
    doReset();
    xfer(1'b0, 1'b1);
    xfer(1'b1, 1'b1);
    xfer(1'b0, 1'b1);
    checkOutput("sif.pulse", 32'(ERR_PULSE), 32'd1);
    checkOutput("sif.inFrame", 32'(IN_FRAME), 32'd1);
    xfer(1'b1, 1'b1);
    checkOutput("sif.pulseGone", 32'(ERR_PULSE), 32'd0);
    xfer(1'b1, 1'b0);
    checkFlags("sif", 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("sif.frameCnt", FRAME_CNT, 32'd1);
    checkOutput("sif.lastLen", 32'(LAST_LEN), 32'd3);

    // SOF+EOF presented without a transfer, then a 2-word frame.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("nx.pulse", 32'(ERR_PULSE), 32'd0);
    checkFlags("nx.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    xfer(1'b0, 1'b1);
    xfer(1'b1, 1'b0);
    checkFlags("nx", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("nx.frameCnt", FRAME_CNT, 32'd1);
    checkOutput("nx.lastLen", 32'(LAST_LEN), 32'd2);

    // EOF-only in IDLE, repeated error pulses, and clear colliding with a new error.
    doReset();
    xfer(1'b1, 1'b0);
    checkFlags("ns", 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("ns.pulse", 32'(ERR_PULSE), 32'd1);
    xfer(1'b1, 1'b1);
    checkOutput("ns.pulseAgain", 32'(ERR_PULSE), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkFlags("ns.clrNew", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("ns.clrPulse", 32'(ERR_PULSE), 32'd1);

    // SOF+EOF inside a frame sets both flags and closes without counting.
    doReset();
    xfer(1'b0, 1'b1);
    xfer(1'b1, 1'b1);
    xfer(1'b0, 1'b0);
    checkFlags("fse", 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("fse.inFrame", 32'(IN_FRAME), 32'd0);
    checkOutput("fse.frameCnt", FRAME_CNT, 32'd0);

    // Reset mid-frame, then a data word without SOF.
    doReset();
    xfer(1'b0, 1'b1);
    xfer(1'b1, 1'b1);
    RESET = 1'b1;
    xfer(1'b1, 1'b1);
    RESET = 1'b0;
    checkOutput("mr.inFrame", 32'(IN_FRAME), 32'd0);
    checkFlags("mr.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    xfer(1'b1, 1'b1);
    checkOutput("mr.noSof", 32'(ERR_NO_SOF), 32'd1);
    checkOutput("mr.frameCnt", FRAME_CNT, 32'd0);

    // 6-word frame against MAX_LEN=4.
    doReset();
    xfer(1'b0, 1'b1);
    xfer(1'b1, 1'b1);
    xfer(1'b1, 1'b1);
    xfer(1'b1, 1'b1);
    checkOutput("ln.atMax", 32'(ERR_LONG), 32'd0);
    checkOutput("ln.atMaxPulse", 32'(ERR_PULSE), 32'd0);
    xfer(1'b1, 1'b1);
    checkOutput("ln.over", 32'(ERR_LONG), 32'(LONG_EN));
    checkOutput("ln.overPulse", 32'(ERR_PULSE), 32'(LONG_EN));
    xfer(1'b1, 1'b0);
    checkOutput("ln.eofPulse", 32'(ERR_PULSE), 32'd0);
    checkFlags("ln", 1'b0, 1'b0, 1'b0, LONG_EN);
    checkOutput("ln.frameCnt", FRAME_CNT, 32'd1);
    checkOutput("ln.lastLen", 32'(LAST_LEN), 32'd6);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkFlags("ln.clr", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
